verdict_stream_packer: RTL and testbench

// - Downstream of the Clash-generated RTLola monitor (topEntity). Captures every cycle where any output stream is active.
// - Timestamps each capture, buffers it in a record FIFO, then serialises it as header + payload words over a valid/ready stream.
// - Gives host / trace logic a lossless verdict stream; overflow is counted, never silent.

---
 rtl/verdict_pkg.sv | 25 ++
 rtl/verdict_record_fifo.sv | 50 +++++
 rtl/verdict_stream_packer.sv | 166 ++++++++++++++++
 tb/tb_verdict_stream_packer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verdict_pkg.sv
// Shared definitions for the verdict stream packer: header field positions,
// default record layout and the serialiser state encoding.
package verdict_pkg;

  localparam int DEF_NUM_OUT    = 4;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_TS_W       = 32;
  localparam int DEF_FIFO_DEPTH = 16;

  localparam int HDR_DROP_BIT = 15;
  localparam int MASK_LSB     = 0;

  typedef struct packed {
    logic [DEF_TS_W-1:0]                ts;
    logic [DEF_NUM_OUT-1:0]             mask;
    logic [DEF_NUM_OUT*DEF_DATA_W-1:0]  data;
  } verdict_rec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } verdict_state_e;

endpackage

// File: rtl/verdict_record_fifo.sv
// Synchronous record FIFO with fall-through read port; a push into a full
// FIFO is accepted when a pop happens on the same edge.
module verdict_record_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/verdict_stream_packer.sv
// Captures active monitor cycles as timestamped records and serialises them
// as header + payload words. Handshake: a word moves on an edge where
// m_valid && m_ready; while m_valid && !m_ready the output word is frozen.
module verdict_stream_packer
  import verdict_pkg::*;
#(
  parameter int NUM_OUT    = DEF_NUM_OUT,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TS_W       = DEF_TS_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_OUT*DATA_W-1:0]     out_data,
  input  logic [NUM_OUT-1:0]            out_aktv,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_valid,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic [15:0]                   drop_cnt,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output verdict_state_e                fsm_state
);

  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef struct packed {
    logic [TS_W-1:0]           ts;
    logic [NUM_OUT-1:0]        mask;
    logic [NUM_OUT*DATA_W-1:0] data;
  } rec_t;

  verdict_state_e state;
  logic [TS_W-1:0] ts_q;
  rec_t            rec_q;
  rec_t            push_rec;
  rec_t            head_rec;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] low_idx;
  logic [IDX_W-1:0] nxt_idx;
  logic            low_more;
  logic            nxt_more;
  logic            drop_pending;
  logic            capture;
  logic            pop;
  logic            push;
  logic            drop;
  logic            fifo_full;
  logic            fifo_empty;

  function automatic logic [DATA_W-1:0] make_header(rec_t r, logic dp);
    logic [DATA_W-1:0] h;
    h = '0;
    h[DATA_W-1 -: TS_W]        = r.ts;
    h[HDR_DROP_BIT]            = dp;
    h[MASK_LSB +: NUM_OUT]     = r.mask;
    return h;
  endfunction

  assign capture  = en && (|out_aktv);
  assign pop      = !fifo_empty && ((state == IDLE) || (state == PAY && m_ready && m_last));
  assign push     = capture && (!fifo_full || pop);
  assign drop     = capture && fifo_full && !pop;
  assign push_rec = '{ts: ts_q, mask: out_aktv, data: out_data};
  assign fsm_state = state;

  verdict_record_fifo #(.WIDTH($bits(rec_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (push_rec),
    .pop     (pop),
    .rd_data (head_rec),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Lowest set bit, and next set bit above the current index, of the held mask.
  always_comb begin
    low_idx  = '0;
    nxt_idx  = idx_q;
    low_more = 1'b0;
    nxt_more = 1'b0;
    for (int i = NUM_OUT-1; i >= 0; i--) begin
      if (rec_q.mask[i]) low_idx = IDX_W'(i);
      if (rec_q.mask[i] && i > int'(idx_q)) nxt_idx = IDX_W'(i);
    end
    for (int i = 0; i < NUM_OUT; i++) begin
      if (rec_q.mask[i] && i > int'(low_idx)) low_more = 1'b1;
      if (rec_q.mask[i] && i > int'(nxt_idx)) nxt_more = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q         <= '0;
      drop_cnt     <= '0;
      overflow     <= 1'b0;
      drop_pending <= 1'b0;
    end else begin
      if (en) ts_q <= ts_q + 1'b1;
      if (drop) begin
        overflow     <= 1'b1;
        drop_pending <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      end else if (state == HDR && m_ready && m_data[HDR_DROP_BIT]) begin
        drop_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rec_q   <= '0;
      idx_q   <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            rec_q   <= head_rec;
            m_data  <= make_header(head_rec, drop_pending);
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            state   <= HDR;
          end
        end
        HDR: begin
          if (m_ready) begin
            idx_q  <= low_idx;
            m_data <= rec_q.data[int'(low_idx)*DATA_W +: DATA_W];
            m_last <= !low_more;
            state  <= PAY;
          end
        end
        PAY: begin
          if (m_ready) begin
            if (!m_last) begin
              idx_q  <= nxt_idx;
              m_data <= rec_q.data[int'(nxt_idx)*DATA_W +: DATA_W];
              m_last <= !nxt_more;
            end else if (!fifo_empty) begin
              rec_q  <= head_rec;
              m_data <= make_header(head_rec, drop_pending);
              m_last <= 1'b0;
              state  <= HDR;
            end else begin
              m_data  <= '0;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_verdict_stream_packer.sv
// Scenario bench for verdict_stream_packer: expected words are queued when a
// capture is driven and checked as each word is accepted on the output.
module tb_verdict_stream_packer;
  import verdict_pkg::*;

  localparam int NUM_OUT    = 4;
  localparam int DATA_W     = 64;
  localparam int TS_W       = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic                        clk;
  logic                        rst;
  logic                        en;
  logic [NUM_OUT*DATA_W-1:0]   out_data;
  logic [NUM_OUT-1:0]          out_aktv;
  logic [DATA_W-1:0]           m_data;
  logic                        m_valid;
  logic                        m_last;
  logic                        m_ready;
  logic [15:0]                 drop_cnt;
  logic                        overflow;
  logic [LVL_W-1:0]            fifo_level;
  verdict_state_e              fsm_state;

  logic [DATA_W-1:0] exp_q[$];
  logic              exp_last_q[$];
  logic [TS_W-1:0]   ts_m;
  int vectors;
  int miscompares;

  verdict_stream_packer #(
    .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .TS_W(TS_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .out_data(out_data), .out_aktv(out_aktv),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .drop_cnt(drop_cnt), .overflow(overflow), .fifo_level(fifo_level),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timestamp: counts enabled edges, cleared by reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) ts_m <= '0;
    else if (en) ts_m <= ts_m + 1'b1;
  end

  // Scoreboard: every accepted word is matched against the expected queue.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_word: got data=%h last=%0b, required no transfer", m_data, m_last);
      end else begin
        logic [DATA_W-1:0] ed;
        logic              el;
        ed = exp_q.pop_front();
        el = exp_last_q.pop_front();
        if (m_data !== ed || m_last !== el) begin
          miscompares++;
          $display("FAIL stream_word: got data=%h last=%0b, required data=%h last=%0b",
                   m_data, m_last, ed, el);
        end
      end
    end
  end

  // driver tasks: called at posedge+1, return at posedge+1
  task automatic cap(input logic [NUM_OUT-1:0] mask, input logic [NUM_OUT*DATA_W-1:0] data,
                     input logic dbit, input bit kept);
    logic [DATA_W-1:0] h;
    en       = 1'b1;
    out_aktv = mask;
    out_data = data;
    if (kept) begin
      h = '0;
      h[DATA_W-1 -: TS_W] = ts_m;
      h[15] = dbit;
      h[NUM_OUT-1:0] = mask;
      exp_q.push_back(h);
      exp_last_q.push_back(1'b0);
      for (int i = 0; i < NUM_OUT; i++) begin
        if (mask[i]) begin
          exp_q.push_back(data[i*DATA_W +: DATA_W]);
          exp_last_q.push_back((mask >> (i+1)) == '0);
        end
      end
    end
    @(posedge clk); #1;
    out_aktv = '0;
  endtask

  task automatic drain(input bit rnd);
    int c;
    c = 0;
    while (!(exp_q.size() == 0 && !m_valid) && c < 800) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      c++;
    end
    m_ready = 1'b1;
    vectors++;
    if (exp_q.size() != 0 || m_valid) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d words still expected, m_valid=%0b, required 0 and 0",
               exp_q.size(), m_valid);
    end
  endtask

  function automatic logic [NUM_OUT*DATA_W-1:0] rand_data();
    logic [NUM_OUT*DATA_W-1:0] d;
    for (int i = 0; i < NUM_OUT*DATA_W/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic test_reset();
    vectors += 6;
    if (m_valid !== 1'b0)     begin miscompares++; $display("FAIL reset_m_valid: got %0b, required 0", m_valid); end
    if (m_last !== 1'b0)      begin miscompares++; $display("FAIL reset_m_last: got %0b, required 0", m_last); end
    if (m_data !== '0)        begin miscompares++; $display("FAIL reset_m_data: got %h, required 0", m_data); end
    if (drop_cnt !== 16'd0)   begin miscompares++; $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt); end
    if (overflow !== 1'b0)    begin miscompares++; $display("FAIL reset_overflow: got %0b, required 0", overflow); end
    if (fifo_level !== '0 || fsm_state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_level_state: got level=%0d state=%0d, required 0 and IDLE", fifo_level, fsm_state);
    end
  endtask

  task automatic test_single();
    logic [NUM_OUT*DATA_W-1:0] d;
    m_ready = 1'b1;
    d = '0;
    d[63:0] = 64'd5;
    cap(4'b0001, d, 1'b0, 1'b1);
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early: got m_valid=%0b, required 0", m_valid); end
    @(posedge clk); #1;
    vectors++;
    if (m_valid !== 1'b1 || m_last !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_header: got m_valid=%0b m_last=%0b, required 1 and 0", m_valid, m_last);
    end
    drain(1'b0);
  endtask

  task automatic test_full_mask();
    cap(4'b1111, {64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd2, 64'd1}, 1'b0, 1'b1);
    drain(1'b0);
  endtask

  task automatic test_sparse();
    cap(4'b1010, rand_data(), 1'b0, 1'b1);
    drain(1'b0);
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] snap_d;
    logic snap_l, snap_v;
    m_ready = 1'b0;
    cap(4'b1111, rand_data(), 1'b0, 1'b1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    snap_d = m_data; snap_l = m_last; snap_v = m_valid;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (m_data !== snap_d || m_last !== snap_l || m_valid !== snap_v || snap_v !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_stable: got data=%h last=%0b valid=%0b, required data=%h last=%0b valid=1",
                 m_data, m_last, m_valid, snap_d, snap_l);
      end
    end
    drain(1'b0);
  endtask

  task automatic test_back_to_back();
    logic [NUM_OUT-1:0] mk;
    m_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      mk = 4'($urandom_range(1, 15));
      cap(mk, rand_data(), 1'b0, 1'b1);
    end
    drain(1'b1);
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    // One record is held in the output stage, so the FIFO fills behind it.
    cap(4'b0001, rand_data(), 1'b0, 1'b1);
    @(posedge clk); #1;
    for (int r = 0; r < FIFO_DEPTH + 3; r++)
      cap(4'($urandom_range(1, 15)), rand_data(), (r == 0), (r < FIFO_DEPTH));
    vectors += 3;
    if (fifo_level !== LVL_W'(FIFO_DEPTH)) begin miscompares++; $display("FAIL ovf_level: got %0d, required %0d", fifo_level, FIFO_DEPTH); end
    if (drop_cnt !== 16'd3) begin miscompares++; $display("FAIL ovf_drop_cnt: got %0d, required 3", drop_cnt); end
    if (overflow !== 1'b1)  begin miscompares++; $display("FAIL ovf_sticky: got %0b, required 1", overflow); end
    drain(1'b0);
    vectors++;
    if (overflow !== 1'b1 || drop_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL ovf_after_drain: got overflow=%0b drop_cnt=%0d, required 1 and 3", overflow, drop_cnt);
    end
  endtask

  task automatic test_enable();
    int seen;
    seen = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      en = 1'b0;
      out_aktv = 4'($urandom_range(0, 15));
      out_data = rand_data();
      @(posedge clk); #1;
      if (m_valid) seen++;
    end
    out_aktv = '0;
    vectors += 2;
    if (seen != 0)          begin miscompares++; $display("FAIL en_low_output: got %0d valid cycles, required 0", seen); end
    if (fifo_level !== '0)  begin miscompares++; $display("FAIL en_low_level: got %0d, required 0", fifo_level); end
    cap(4'b0100, rand_data(), 1'b0, 1'b1);
    drain(1'b0);
  endtask

  task automatic test_reset_mid_record();
    logic [NUM_OUT*DATA_W-1:0] d;
    m_ready = 1'b0;
    cap(4'b1111, rand_data(), 1'b0, 1'b1);
    cap(4'b0011, rand_data(), 1'b0, 1'b1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    vectors += 2;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset_valid: got %0b, required 0", m_valid); end
    if (fifo_level !== '0 || drop_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL async_reset_state: got level=%0d drop_cnt=%0d, required 0 and 0", fifo_level, drop_cnt);
    end
    exp_q.delete();
    exp_last_q.delete();
    en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_ready = 1'b1;
    d = rand_data();
    cap(4'b1000, d, 1'b0, 1'b1);
    @(posedge clk); #1;
    vectors++;
    if (m_valid !== 1'b1 || m_data[DATA_W-1 -: TS_W] !== '0) begin
      miscompares++;
      $display("FAIL post_reset_ts: got valid=%0b ts=%0d, required valid=1 ts=0",
               m_valid, m_data[DATA_W-1 -: TS_W]);
    end
    drain(1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    en = 1'b1;
    out_aktv = '0;
    out_data = '0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    test_single();
    test_full_mask();
    test_sparse();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_enable();
    test_reset_mid_record();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
